// File: rtl/fir_ctrl_pkg.sv
// rtl/fir_ctrl_pkg.sv - shared state type, impulse constant and size defaults for the FIR coefficient controller
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PEND = 2'd2
  } fir_ctrl_state_e;

  localparam int DEFAULT_NUM_COEFFS  = 64;
  localparam int DEFAULT_COEFF_WIDTH = 16;

  // Value held in tap 0 after reset; every other tap is zero, so the FIR passes samples through.
  localparam int IMPULSE_TAP0 = 1;

endpackage

// File: rtl/fir_coeff_sequencer_if.sv
// rtl/fir_coeff_sequencer_if.sv - configuration stream, sample strobe and coefficient bus of the sequencer
interface fir_coeff_sequencer_if
  import fir_ctrl_pkg::*;
#(
  parameter int NUM_COEFFS  = DEFAULT_NUM_COEFFS,
  parameter int COEFF_WIDTH = DEFAULT_COEFF_WIDTH
);

  logic                                   cfg_start;
  logic [COEFF_WIDTH-1:0]                 cfg_data;
  logic                                   cfg_valid;
  logic                                   cfg_ready;
  logic                                   sample_strobe;
  logic [NUM_COEFFS-1:0][COEFF_WIDTH-1:0] coeffs;
  logic                                   busy;
  logic                                   swap_done;
  logic                                   cfg_error;

  // Control path / audio side: drives the load stream and the sample strobe.
  modport master (
    output cfg_start, cfg_data, cfg_valid, sample_strobe,
    input  cfg_ready, coeffs, busy, swap_done, cfg_error
  );

  // Sequencer side.
  modport slave (
    input  cfg_start, cfg_data, cfg_valid, sample_strobe,
    output cfg_ready, coeffs, busy, swap_done, cfg_error
  );

endinterface

// File: rtl/fir_coeff_shadow.sv
// rtl/fir_coeff_shadow.sv - shadow coefficient register file with indexed write and full-width read
module fir_coeff_shadow
  import fir_ctrl_pkg::*;
#(
  parameter int  NUM_COEFFS  = DEFAULT_NUM_COEFFS,
  parameter int  COEFF_WIDTH = DEFAULT_COEFF_WIDTH,
  localparam int IDX_W       = $clog2(NUM_COEFFS)
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   i_we,
  input  logic [IDX_W-1:0]                       i_idx,
  input  logic [COEFF_WIDTH-1:0]                 i_data,
  output logic [NUM_COEFFS-1:0][COEFF_WIDTH-1:0] o_bank
);

  localparam logic [NUM_COEFFS-1:0][COEFF_WIDTH-1:0] IMPULSE =
    {{((NUM_COEFFS-1)*COEFF_WIDTH){1'b0}}, COEFF_WIDTH'(IMPULSE_TAP0)};

  logic [NUM_COEFFS-1:0][COEFF_WIDTH-1:0] r_bank;

  // One tap written per accepted beat; untouched taps keep whatever they held before.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank <= IMPULSE;
    end else if (i_we) begin
      r_bank[i_idx] <= i_data;
    end
  end

  assign o_bank = r_bank;

endmodule

// File: rtl/fir_coeff_sequencer.sv
// rtl/fir_coeff_sequencer.sv - loads a coefficient set into a shadow bank and commits it on a sample boundary
module fir_coeff_sequencer
  import fir_ctrl_pkg::*;
#(
  parameter int NUM_COEFFS  = DEFAULT_NUM_COEFFS,
  parameter int COEFF_WIDTH = DEFAULT_COEFF_WIDTH
) (
  input logic                    clk,
  input logic                    rst_n,
  fir_coeff_sequencer_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_COEFFS);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_LOAD = ST_LOAD;
  localparam logic [1:0] S_PEND = ST_PEND;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_COEFFS - 1);

  localparam logic [NUM_COEFFS-1:0][COEFF_WIDTH-1:0] IMPULSE =
    {{((NUM_COEFFS-1)*COEFF_WIDTH){1'b0}}, COEFF_WIDTH'(IMPULSE_TAP0)};

  logic [1:0]                             r_state;
  logic [IDX_W-1:0]                       r_index;
  logic [NUM_COEFFS-1:0][COEFF_WIDTH-1:0] r_active;
  logic                                   r_swap_done;
  logic                                   r_cfg_error;

  logic                                   w_cfg_ready;
  logic                                   w_beat;
  logic                                   w_commit;
  logic                                   w_abort;
  logic [NUM_COEFFS-1:0][COEFF_WIDTH-1:0] w_shadow;

  // A restart pulse blocks the beat of the same cycle, so it can never land at a stale index.
  assign w_cfg_ready = (r_state == S_LOAD) && !bus.cfg_start;
  assign w_beat      = w_cfg_ready && bus.cfg_valid;
  assign w_commit    = (r_state == S_PEND) && bus.sample_strobe;
  // A restart is an abort unless a commit consumes the pending set on the same edge.
  assign w_abort     = bus.cfg_start &&
                       ((r_state == S_LOAD) || ((r_state == S_PEND) && !bus.sample_strobe));

  fir_coeff_shadow #(
    .NUM_COEFFS  (NUM_COEFFS),
    .COEFF_WIDTH (COEFF_WIDTH)
  ) u_shadow (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_we   (w_beat),
    .i_idx  (r_index),
    .i_data (bus.cfg_data),
    .o_bank (w_shadow)
  );

  // Load sequencing: the final tap write moves to PEND instead of letting the index wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_index <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cfg_start) begin
            r_state <= S_LOAD;
            r_index <= '0;
          end
        end
        S_LOAD: begin
          if (bus.cfg_start) begin
            r_index <= '0;
          end else if (bus.cfg_valid) begin
            if (r_index == LAST_IDX) begin
              r_state <= S_PEND;
              r_index <= '0;
            end else begin
              r_index <= r_index + IDX_W'(1);
            end
          end
        end
        S_PEND: begin
          if (bus.cfg_start) begin
            r_state <= S_LOAD;
            r_index <= '0;
          end else if (bus.sample_strobe) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_index <= '0;
        end
      endcase
    end
  end

  // Active bank swaps only on a sample boundary; status pulses are registered one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active    <= IMPULSE;
      r_swap_done <= 1'b0;
      r_cfg_error <= 1'b0;
    end else begin
      if (w_commit) begin
        r_active <= w_shadow;
      end
      r_swap_done <= w_commit;
      r_cfg_error <= w_abort;
    end
  end

  assign bus.cfg_ready = w_cfg_ready;
  assign bus.coeffs    = r_active;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.swap_done = r_swap_done;
  assign bus.cfg_error = r_cfg_error;

endmodule

// File: doc/fir_coeff_sequencer.md
# fir_coeff_sequencer

Coefficient controller for the audio FIR filter. Accepts a new coefficient set as a serial valid/ready stream from the control path, stages it in a shadow bank, and commits it to the active bank only on a sample boundary (`sample_strobe`, the same pulse that drives the FIR's input-valid). The FIR therefore never computes a sample from a mixed coefficient set. The active bank drives the FIR `coeffs` bus directly.

## Interface
- `NUM_COEFFS`, 64, number of taps; must be ≥2.
- `COEFF_WIDTH`, 16, signed coefficient width.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_start`  in  1  single-cycle pulse; begins a new load and clears the write index.
- `cfg_data`  in  COEFF_WIDTH  next coefficient, tap 0 first.
- `cfg_valid`  in  1  `cfg_data` is valid.
- `cfg_ready`  out  1  block accepts `cfg_data` this cycle.
- `sample_strobe`  in  1  audio sample boundary pulse.
- `coeffs`  out  [NUM_COEFFS-1:0][COEFF_WIDTH-1:0]  active coefficient bank, signed, registered.
- `busy`  out  1  high whenever state ≠ IDLE.
- `swap_done`  out  1  one-cycle pulse on the cycle after a commit.
- `cfg_error`  out  1  one-cycle pulse when a load is aborted.

## Operation
- States:
  - IDLE: `cfg_ready`=0.
  - LOAD: `cfg_ready` = !`cfg_start`.
  - PEND: `cfg_ready`=0; a full set is staged.
- Transitions:
  - IDLE → LOAD on `cfg_start`; index ← 0.
  - LOAD: on `cfg_valid && cfg_ready`, shadow[index] ← `cfg_data` and index increments. The write at index NUM_COEFFS-1 moves the block to PEND.
  - PEND → IDLE on `sample_strobe`: active ← shadow, and `swap_done` pulses next cycle.
- `cfg_start` in LOAD restarts the load: index ← 0, `cfg_error` pulses, and the shadow keeps stale entries until they are overwritten. Any beat presented in the same cycle is dropped.
- `cfg_start` in PEND without `sample_strobe` discards the pending set: → LOAD, index ← 0, `cfg_error` pulses.
- `cfg_start` and `sample_strobe` together in PEND: the commit happens first (active ← shadow, `swap_done` pulses), then → LOAD with no error.
- `cfg_valid` outside LOAD is ignored. `sample_strobe` outside PEND has no effect.
- Index width is $clog2(NUM_COEFFS). The index never wraps: reaching NUM_COEFFS-1 forces PEND.
- No arithmetic is performed. Coefficients pass through bit-exact.

## Timing
- Reset (async assert, sync release):
  - state = IDLE, index = 0.
  - `cfg_ready`, `busy`, `swap_done`, `cfg_error` = 0.
  - Active and shadow banks = impulse: tap 0 = 1, all other taps = 0. This makes the FIR a passthrough.
- `cfg_start` at edge N → `cfg_ready`=1 from cycle N+1. The fastest full load takes NUM_COEFFS cycles after that.
- The commit register updates on the same edge that `sample_strobe` is sampled high. The FIR sample taken on that edge uses the old set; the next sample uses the new set.
- `swap_done` is high in the cycle after the commit edge, and `busy` is low in that same cycle.
- Reset asserted mid-LOAD or in PEND aborts everything. The active bank returns to the impulse, and no `swap_done` or `cfg_error` is produced.

## Structure
- Package `fir_ctrl_pkg`:
  - state enum (IDLE, LOAD, PEND)
  - `IMPULSE_TAP0` constant
  - shared defaults for `NUM_COEFFS` / `COEFF_WIDTH`
- Sub-module `fir_coeff_shadow`: the shadow register file with an indexed write port, a full-width read, and a reset to impulse.
- The FSM, index counter and active bank stay in the top level.

## Test plan
- Reset, then check `coeffs`: tap 0 = 1, taps 1..63 = 0; `busy`=0, `cfg_ready`=0.
- Pulse `cfg_start`, stream taps i = 16'(i+100) with `cfg_valid` held high, then strobe 5 cycles later:
  - the active bank is unchanged until the strobe edge, then tap 63 = 163;
  - `swap_done` pulses once.
- Full load with random `cfg_valid` gaps and no strobe for 200 cycles: the block stays in PEND, `cfg_ready`=0, and the active bank is unchanged.
- `cfg_start` after 10 beats, then a full load of 16'hAAAA: `cfg_error` pulses once, and after the strobe all taps = 16'hAAAA.
- In PEND, `cfg_start` and `sample_strobe` in the same cycle:
  - commit occurs and `swap_done` pulses with no `cfg_error`;
  - the block enters LOAD with `cfg_ready`=1 on the next cycle.
- Assert `rst_n` low mid-LOAD at beat 30: all outputs take their reset values asynchronously and `coeffs` returns to the impulse.
